length_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single bit-length unit (md_start/md_end handshake, num_in in, len_out back) among NUM_REQ requesters. It latches one requester's operand, issues a one-cycle md_start, waits for md_end, captures the length and returns it to that requester with a one-cycle ack. A WAIT timeout guarantees forward progress if the unit never answers.

---
 rtl/length_arbiter.sv | 141 ++++++++++++++
 tb/tb_length_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/length_arbiter.sv
// Round-robin arbiter that time-shares one bit-length unit among NUM_REQ requesters.
// Each transaction: latch operand, pulse md_start, wait for md_end_in (or timeout), ack the winner.
module length_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 8,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_num,
    output logic [NUM_REQ-1:0]          ack,
    output logic [LEN_W-1:0]            rsp_len,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        rsp_err,
    output logic                        busy,
    output logic                        md_start,
    output logic [DATA_W-1:0]           num_out,
    input  logic                        md_end_in,
    input  logic [LEN_W-1:0]            len_in
);

    // state  | meaning
    // IDLE   | sample req, pick a winner by round-robin
    // ISSUE  | md_start pulse, clear timeout counter
    // WAIT   | wait for md_end_in or timeout
    // RESP   | one-cycle ack to the winner
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int CNT_W = 8;

    state_t              state_q;
    logic [ID_W-1:0]     last_q;
    logic [ID_W-1:0]     grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [LEN_W-1:0]    rsp_len_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic                rsp_err_q;
    logic                busy_q;
    logic                md_start_q;
    logic [DATA_W-1:0]   num_out_q;

    logic                found_hi_d, found_lo_d;
    logic [ID_W-1:0]     win_hi_d, win_lo_d, win_d;
    logic [DATA_W-1:0]   op_hi_d, op_lo_d, op_d;

    // Winner is the lowest requester above last grant, else the lowest requester overall.
    always_comb begin
        found_hi_d = 1'b0;
        found_lo_d = 1'b0;
        win_hi_d   = '0;
        win_lo_d   = '0;
        op_hi_d    = '0;
        op_lo_d    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !found_hi_d && (i > int'(last_q))) begin
                found_hi_d = 1'b1;
                win_hi_d   = ID_W'(i);
                op_hi_d    = req_num[i*DATA_W +: DATA_W];
            end
            if (req[i] && !found_lo_d) begin
                found_lo_d = 1'b1;
                win_lo_d   = ID_W'(i);
                op_lo_d    = req_num[i*DATA_W +: DATA_W];
            end
        end
        win_d = found_hi_d ? win_hi_d : win_lo_d;
        op_d  = found_hi_d ? op_hi_d  : op_lo_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= ID_W'(NUM_REQ - 1);
            grant_q    <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            rsp_len_q  <= '0;
            rsp_id_q   <= '0;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            md_start_q <= 1'b0;
            num_out_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= '0;
                    if (found_lo_d) begin
                        grant_q    <= win_d;
                        last_q     <= win_d;
                        num_out_q  <= op_d;
                        md_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    md_start_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the same cycle as the timeout takes priority.
                    if (md_end_in) begin
                        rsp_len_q <= len_in;
                        rsp_err_q <= 1'b0;
                        rsp_id_q  <= grant_q;
                        ack_q     <= NUM_REQ'(1) << grant_q;
                        state_q   <= S_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        rsp_len_q <= '0;
                        rsp_err_q <= 1'b1;
                        rsp_id_q  <= grant_q;
                        ack_q     <= NUM_REQ'(1) << grant_q;
                        state_q   <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack      = ack_q;
    assign rsp_len  = rsp_len_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_err  = rsp_err_q;
    assign busy     = busy_q;
    assign md_start = md_start_q;
    assign num_out  = num_out_q;

endmodule

// File: tb/tb_length_arbiter.sv
// Directed + randomized bench for length_arbiter; the bench plays the length unit itself.
module tb_length_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int LW = 8;
    localparam int IW = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_num;
    logic [N-1:0]    ack;
    logic [LW-1:0]   rsp_len;
    logic [IW-1:0]   rsp_id;
    logic            rsp_err;
    logic            busy;
    logic            md_start;
    logic [DW-1:0]   num_out;
    logic            md_end_in;
    logic [LW-1:0]   len_in;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_model = N - 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    length_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LEN_W(LW), .ID_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_num(req_num), .ack(ack),
        .rsp_len(rsp_len), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy),
        .md_start(md_start), .num_out(num_out), .md_end_in(md_end_in), .len_in(len_in)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rotating priority: first requester found walking forward from the last grant.
    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        int j;
        for (int d = 1; d <= N; d++) begin
            j = (last + d) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic int bitlen(input logic [63:0] x);
        for (int i = 63; i >= 0; i--) if (x[i]) return i + 1;
        return 0;
    endfunction

    // Entered at a negedge in IDLE; returns at the negedge of the IDLE cycle after ack.
    // lat = WAIT cycle (1-based) in which the unit answers; 0 = it never answers.
    task automatic run_txn(input logic [N-1:0] rv, input int lat, input bit drop, output int ack_cyc);
        int g, exp_ack, len;
        logic [63:0] op;
        chk("idle_busy", busy, 0);
        chk("idle_ack", ack, 0);
        req = rv;
        g = rr_pick(last_model, rv);
        last_model = g;
        op = req_num[g*DW +: DW];
        len = bitlen(op);
        exp_ack = (lat > 0) ? lat + 2 : TO + 3;
        @(negedge clk);
        chk("issue_md_start", md_start, 1);
        chk("issue_num_out", num_out, op);
        chk("issue_busy", busy, 1);
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (c == exp_ack) break;
            chk("wait_ack", ack, 0);
            chk("wait_md_start", md_start, 0);
            chk("wait_num_out", num_out, op);
            md_end_in = (c - 1 == lat);
            len_in = md_end_in ? LW'(len) : LW'($urandom);
        end
        md_end_in = 1'b0;
        ack_cyc = cyc;
        chk("resp_ack", ack, 64'(1) << g);
        chk("resp_id", rsp_id, g);
        chk("resp_len", rsp_len, (lat > 0) ? len : 0);
        chk("resp_err", rsp_err, (lat > 0) ? 0 : 1);
        chk("resp_busy", busy, 1);
        if (drop) req[g] = 1'b0;
        @(negedge clk);
        chk("post_ack", ack, 0);
    endtask

    task automatic quiet_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("quiet_ack", ack, 0);
            chk("quiet_busy", busy, 0);
            chk("quiet_md_start", md_start, 0);
        end
    endtask

    initial begin
        int ac, prev_ac, lat;
        logic [N-1:0] rv;
        rst = 1'b1; req = '0; req_num = '0; md_end_in = 1'b0; len_in = '0;
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_len", rsp_len, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_md_start", md_start, 0);
        chk("rst_num_out", num_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // single request, 1-cycle unit
        req_num[0 +: DW] = 64'h9;
        run_txn(4'b0001, 1, 1, ac);

        // fairness with all four requesting; one ack every 4 cycles
        req_num[0*DW +: DW] = 64'h1;
        req_num[1*DW +: DW] = 64'h2;
        req_num[2*DW +: DW] = 64'h4;
        req_num[3*DW +: DW] = 64'h8;
        prev_ac = 0;
        for (int i = 0; i < 6; i++) begin
            run_txn(4'b1111, 1, 0, ac);
            if (i > 0) chk("rr_period", ac - prev_ac, 4);
            prev_ac = ac;
        end

        // wrap-around: serve 2, then {0,2} must go to 0
        run_txn(4'b0100, 1, 1, ac);
        run_txn(4'b0101, 3, 1, ac);
        chk("wrap_id", rsp_id, 0);
        req = '0;

        // timeout, then a late completion pulse is ignored
        req_num[3*DW +: DW] = 64'hFFFF;
        run_txn(4'b1000, 0, 1, ac);
        md_end_in = 1'b1;
        len_in = 8'd5;
        @(negedge clk);
        md_end_in = 1'b0;
        chk("late_ack", ack, 0);
        quiet_cycles(3);

        // completion in the 16th WAIT cycle
        req_num[1*DW +: DW] = 64'h40;
        run_txn(4'b0010, 16, 1, ac);
        chk("edge_len", rsp_len, 7);

        // reset during WAIT
        req = 4'b0100;
        req_num[2*DW +: DW] = 64'hABCD;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        last_model = N - 1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_md_start", md_start, 0);
        chk("mid_rst_num_out", num_out, 0);
        chk("mid_rst_len", rsp_len, 0);
        chk("mid_rst_err", rsp_err, 0);
        chk("mid_rst_id", rsp_id, 0);
        md_end_in = 1'b1;
        len_in = 8'd3;
        @(negedge clk);
        md_end_in = 1'b0;
        quiet_cycles(3);
        req_num[1*DW +: DW] = 64'h3;
        run_txn(4'b0010, 2, 1, ac);

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++)
                req_num[i*DW +: DW] = {$urandom, $urandom} >> $urandom_range(0, 63);
            rv = N'($urandom_range(1, (1 << N) - 1));
            lat = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TO));
            run_txn(rv, lat, 1'($urandom_range(0, 1)), ac);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
